// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath control from the opcode/funct latched in DECODE; counts retired instructions.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             Link,
    output logic [1:0]       ALUSrc,
    output logic [2:0]       ALUControl,
    output logic             Branch,
    output logic             Jump,
    output logic             JR,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
        instr_t c;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = I_ADDU;
                    6'b100011: c = I_SUBU;
                    6'b001000: c = I_JR;
                    default:   c = I_ILL;
                endcase
            end
            6'b001101: c = I_ORI;
            6'b001111: c = I_LUI;
            6'b100011: c = I_LW;
            6'b101011: c = I_SW;
            6'b000100: c = I_BEQ;
            6'b000010: c = I_J;
            6'b000011: c = I_JAL;
            default:   c = I_ILL;
        endcase
        return c;
    endfunction

    state_t           state, state_next;
    instr_t           kind;
    logic [5:0]       op_q, fn_q;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // DECODE must act on the live IR fields; later states use the latched copy.
    always_comb begin
        if (state == DECODE) kind = classify(opcode, funct);
        else                 kind = classify(op_q, fn_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            op_q  <= '0;
            fn_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (done) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        Link       = 1'b0;
        ALUSrc     = 2'b00;
        ALUControl = 3'b000;
        Branch     = 1'b0;
        Jump       = 1'b0;
        JR         = 1'b0;
        illegal    = 1'b0;

        // ALU setup is held constant across EXEC, MEM and WB.
        if (state == EXEC || state == MEM || state == WB) begin
            case (kind)
                I_SUBU:      ALUControl = 3'b001;
                I_BEQ:       ALUControl = 3'b001;
                I_ORI:  begin ALUControl = 3'b010; ALUSrc = 2'b10; end
                I_LUI:  begin ALUControl = 3'b011; ALUSrc = 2'b11; end
                I_LW, I_SW:  ALUSrc     = 2'b01;
                I_JR:        ALUControl = 3'b100;
                default: ;
            endcase
        end

        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (kind == I_ILL) begin
                    PCWrite    = 1'b1;
                    done       = 1'b1;
                    illegal    = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (kind)
                    I_LW, I_SW: state_next = MEM;
                    I_BEQ: begin
                        Branch     = 1'b1;
                        PCWrite    = 1'b1;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    I_J: begin
                        Jump       = 1'b1;
                        PCWrite    = 1'b1;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    I_JAL: begin
                        Jump       = 1'b1;
                        Link       = 1'b1;
                        RegWrite   = 1'b1;
                        PCWrite    = 1'b1;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    I_JR: begin
                        JR         = 1'b1;
                        PCWrite    = 1'b1;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                if (kind == I_SW) begin
                    MemWrite   = 1'b1;
                    PCWrite    = 1'b1;
                    done       = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            WB: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                done       = 1'b1;
                RegDst     = (kind == I_ADDU) || (kind == I_SUBU);
                MemtoReg   = (kind == I_LW);
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        instr_done = done;

        // Reset silences every output for the cycle, abandoning any pending write.
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            RegDst     = 1'b0;
            Link       = 1'b0;
            ALUSrc     = 2'b00;
            ALUControl = 3'b000;
            Branch     = 1'b0;
            Jump       = 1'b0;
            JR         = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_comb instr_count = reset ? '0 : cnt;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed and random instruction streams checked cycle by
// cycle against a per-instruction expected-output table derived from the control rules.
module tb_mc_controller;

    localparam int CNT_W = 4;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILLOP = 10, K_ILLFN = 11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, RegDst, Link;
    logic [1:0]       ALUSrc;
    logic [2:0]       ALUControl;
    logic             Branch, Jump, JR, instr_done, illegal;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .Link(Link), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .Branch(Branch), .Jump(Jump), .JR(JR),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [16:0] outv;
    assign outv = {IRWrite, PCWrite, RegWrite, MemWrite, MemtoReg, RegDst, Link,
                   ALUSrc, ALUControl, Branch, Jump, JR, instr_done, illegal};

    function automatic int ncyc(input int kind);
        case (kind)
            K_ILLOP, K_ILLFN:       return 2;
            K_BEQ, K_J, K_JAL, K_JR: return 3;
            K_LW:                   return 5;
            default:                return 4;
        endcase
    endfunction

    // Expected output vector for cycle k (1-based) of an instruction of the given kind.
    function automatic logic [16:0] expv(input int kind, input int k);
        logic irw, pcw, rw, mw, m2r, rd, lnk, br, jmp, jr, dn, ill;
        logic [1:0] src;
        logic [2:0] alu;
        bit last;
        {irw, pcw, rw, mw, m2r, rd, lnk, br, jmp, jr, dn, ill} = '0;
        src = 2'b00;
        alu = 3'b000;
        last = (k == ncyc(kind));
        if (k == 1) begin
            irw = 1'b1;
        end else if (kind == K_ILLOP || kind == K_ILLFN) begin
            pcw = 1'b1; dn = 1'b1; ill = 1'b1;
        end else if (k >= 3) begin
            case (kind)
                K_SUBU, K_BEQ: alu = 3'b001;
                K_ORI:  begin alu = 3'b010; src = 2'b10; end
                K_LUI:  begin alu = 3'b011; src = 2'b11; end
                K_LW, K_SW: src = 2'b01;
                K_JR:   alu = 3'b100;
                default: ;
            endcase
            if (last) begin
                pcw = 1'b1;
                dn  = 1'b1;
                rw  = (kind inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL});
                mw  = (kind == K_SW);
                rd  = (kind inside {K_ADDU, K_SUBU});
                m2r = (kind == K_LW);
                br  = (kind == K_BEQ);
                jmp = (kind inside {K_J, K_JAL});
                lnk = (kind == K_JAL);
                jr  = (kind == K_JR);
            end
        end
        return {irw, pcw, rw, mw, m2r, rd, lnk, src, alu, br, jmp, jr, dn, ill};
    endfunction

    function automatic logic [5:0] rand_illegal_op();
        logic [5:0] op;
        op = 6'b111111;
        for (int t = 0; t < 200; t++) begin
            op = 6'($urandom_range(0, 63));
            if (!(op inside {6'd0, 6'd13, 6'd15, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3})) break;
            op = 6'b111111;
        end
        return op;
    endfunction

    function automatic logic [5:0] rand_illegal_fn();
        logic [5:0] fn;
        fn = 6'b000000;
        for (int t = 0; t < 200; t++) begin
            fn = 6'($urandom_range(0, 63));
            if (!(fn inside {6'b100001, 6'b100011, 6'b001000})) break;
            fn = 6'b000000;
        end
        return fn;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset  = 1'b1;
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            #1;
            cnt_model = '0;
            check($sformatf("reset%0d outputs", i), 32'(outv), 32'd0);
            check($sformatf("reset%0d count", i), 32'(instr_count), 32'd0);
        end
    endtask

    // Runs one instruction; a nonzero abort_at raises reset in that cycle instead.
    task automatic run_instr(input int kind, input int abort_at, input logic [5:0] ill_op);
        logic [5:0] op, fn;
        logic [16:0] e;
        fn = 6'($urandom);
        case (kind)
            K_ADDU:  begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU:  begin op = 6'b000000; fn = 6'b100011; end
            K_JR:    begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:   op = 6'b001101;
            K_LUI:   op = 6'b001111;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_BEQ:   op = 6'b000100;
            K_J:     op = 6'b000010;
            K_JAL:   op = 6'b000011;
            K_ILLOP: op = ill_op;
            default: begin op = 6'b000000; fn = rand_illegal_fn(); end
        endcase
        for (int k = 1; k <= ncyc(kind); k++) begin
            @(negedge clk);
            reset = (k == abort_at);
            if (k <= 2) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            #1;
            if (k == abort_at) begin
                cnt_model = '0;
                check($sformatf("k%0d op%h abort c%0d outputs", kind, op, k), 32'(outv), 32'd0);
                check($sformatf("k%0d op%h abort c%0d count", kind, op, k),
                      32'(instr_count), 32'd0);
                return;
            end
            e = expv(kind, k);
            check($sformatf("k%0d op%h fn%h c%0d outputs", kind, op, fn, k), 32'(outv), 32'(e));
            check($sformatf("k%0d op%h c%0d count", kind, op, k),
                  32'(instr_count), 32'(cnt_model));
            if (e[1]) cnt_model = cnt_model + 1'b1;
        end
    endtask

    initial begin
        int kind, abort;
        reset_cycles(2);
        run_instr(K_ADDU, 0, '0);
        run_instr(K_LW, 0, '0);
        reset_cycles(1);
        run_instr(K_SW, 0, '0);
        run_instr(K_BEQ, 0, '0);
        run_instr(K_JAL, 0, '0);
        run_instr(K_JR, 0, '0);
        run_instr(K_ILLOP, 0, 6'b111111);
        run_instr(K_ILLFN, 0, '0);
        run_instr(K_SW, 4, '0);
        run_instr(K_ORI, 0, '0);
        run_instr(K_LUI, 0, '0);
        run_instr(K_SUBU, 0, '0);
        run_instr(K_J, 0, '0);
        for (int i = 0; i < 200; i++) begin
            kind  = $urandom_range(0, 11);
            abort = ($urandom_range(0, 19) == 0) ? $urandom_range(1, ncyc(kind)) : 0;
            run_instr(kind, abort, rand_illegal_op());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
